add_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `add` instance (BIT_NUM-wide, outputs O and carry C) among REQ_NUM requesters. It latches the winning requester's operands and drives them onto the shared adder. It registers the adder result and returns it to that requester over a valid/ready response handshake. It sits between the requester blocks and the single `add` instance, which connects to add_a/add_b/add_o/add_c.

---
 rtl/add_share_arbiter.sv | 173 +++++++++++++++++
 tb/tb_add_share_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_share_arbiter.sv
// add_share_arbiter
//   Round-robin arbiter/sequencer sharing one combinational adder among
//   REQ_NUM requesters. One operation at a time: IDLE samples req and
//   latches the winner's operands, CALC registers the adder result, RESP
//   holds the response until rsp_ready.
// Ports:
//   clk, reset        clock, async active-low reset
//   req               per-requester level request
//   a_in, b_in        packed operands, requester i at [i*BIT_NUM +: BIT_NUM]
//   gnt               one-hot grant pulse (one cycle)
//   add_a, add_b      operands to the shared adder (registered)
//   add_o, add_c      sum/carry back from the shared adder
//   rsp_valid         one-hot response valid, held until rsp_ready
//   rsp_ready         response accepted
//   rsp_o, rsp_c      registered sum/carry
//   rsp_id            index of responding requester
//   busy              state != IDLE
//   op_cnt            completed handshakes, wrapping

// Per-requester operand gate: passes operands only for the selected lane so
// the winner's operands can be picked with a plain OR reduction.
module asa_lane #(
  parameter int BIT_NUM = 4
) (
  input  logic               sel,
  input  logic [BIT_NUM-1:0] a,
  input  logic [BIT_NUM-1:0] b,
  output logic [BIT_NUM-1:0] a_sel,
  output logic [BIT_NUM-1:0] b_sel
);
  assign a_sel = a & {BIT_NUM{sel}};
  assign b_sel = b & {BIT_NUM{sel}};
endmodule

module add_share_arbiter #(
  parameter int BIT_NUM = 4,
  parameter int REQ_NUM = 4,
  parameter int IDX_BIT = 2,
  parameter int CNT_BIT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REQ_NUM-1:0]         req,
  input  logic [REQ_NUM*BIT_NUM-1:0] a_in,
  input  logic [REQ_NUM*BIT_NUM-1:0] b_in,
  output logic [REQ_NUM-1:0]         gnt,
  output logic [BIT_NUM-1:0]         add_a,
  output logic [BIT_NUM-1:0]         add_b,
  input  logic [BIT_NUM-1:0]         add_o,
  input  logic                       add_c,
  output logic [REQ_NUM-1:0]         rsp_valid,
  input  logic                       rsp_ready,
  output logic [BIT_NUM-1:0]         rsp_o,
  output logic                       rsp_c,
  output logic [IDX_BIT-1:0]         rsp_id,
  output logic                       busy,
  output logic [CNT_BIT-1:0]         op_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t state, state_nxt;

  logic [IDX_BIT-1:0] ptr;
  logic [IDX_BIT-1:0] win;
  logic [IDX_BIT-1:0] scan_idx;
  logic               win_vld;
  logic [REQ_NUM-1:0] win_oh;

  logic [REQ_NUM-1:0][BIT_NUM-1:0] a_lanes, b_lanes, a_msk, b_msk;
  logic [BIT_NUM-1:0] a_pick, b_pick;
  logic [BIT_NUM-1:0] op_a, op_b;

  assign a_lanes = a_in;
  assign b_lanes = b_in;

  // Rotating search starting at ptr; IDX_BIT-wide addition wraps modulo
  // REQ_NUM because REQ_NUM == 2**IDX_BIT.
  always_comb begin
    win      = '0;
    win_vld  = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      scan_idx = ptr + IDX_BIT'(k);
      if (!win_vld && req[scan_idx]) begin
        win     = scan_idx;
        win_vld = 1'b1;
      end
    end
  end

  assign win_oh = win_vld ? (REQ_NUM'(1) << win) : '0;

  generate
    for (genvar i = 0; i < REQ_NUM; i++) begin : g_lane
      asa_lane #(.BIT_NUM(BIT_NUM)) u_lane (
        .sel   (win_oh[i]),
        .a     (a_lanes[i]),
        .b     (b_lanes[i]),
        .a_sel (a_msk[i]),
        .b_sel (b_msk[i])
      );
    end
  endgenerate

  always_comb begin
    a_pick = '0;
    b_pick = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      a_pick = a_pick | a_msk[i];
      b_pick = b_pick | b_msk[i];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld)   state_nxt = CALC;
      CALC:                   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_o     <= '0;
      rsp_c     <= 1'b0;
      rsp_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          op_a   <= a_pick;
          op_b   <= b_pick;
          rsp_id <= win;
          gnt    <= win_oh;
        end
        CALC: begin
          rsp_o     <= add_o;
          rsp_c     <= add_c;
          gnt       <= '0;
          rsp_valid <= REQ_NUM'(1) << rsp_id;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= '0;
          // Requester just served drops to lowest priority.
          ptr       <= rsp_id + IDX_BIT'(1);
          op_cnt    <= op_cnt + CNT_BIT'(1);
        end
        default: ;
      endcase
    end
  end

  assign add_a = op_a;
  assign add_b = op_b;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_add_share_arbiter.sv
module tb_add_share_arbiter;
  localparam int BIT_NUM = 4;
  localparam int REQ_NUM = 4;
  localparam int IDX_BIT = 2;
  localparam int CNT_BIT = 8;

  logic                       clk;
  logic                       reset;
  logic [REQ_NUM-1:0]         req;
  logic [REQ_NUM*BIT_NUM-1:0] a_in, b_in;
  logic [REQ_NUM-1:0]         gnt;
  logic [BIT_NUM-1:0]         add_a, add_b, add_o;
  logic                       add_c;
  logic [REQ_NUM-1:0]         rsp_valid;
  logic                       rsp_ready;
  logic [BIT_NUM-1:0]         rsp_o;
  logic                       rsp_c;
  logic [IDX_BIT-1:0]         rsp_id;
  logic                       busy;
  logic [CNT_BIT-1:0]         op_cnt;

  add_share_arbiter #(.BIT_NUM(BIT_NUM), .REQ_NUM(REQ_NUM), .IDX_BIT(IDX_BIT), .CNT_BIT(CNT_BIT)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .add_a(add_a), .add_b(add_b), .add_o(add_o), .add_c(add_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_o(rsp_o), .rsp_c(rsp_c),
    .rsp_id(rsp_id), .busy(busy), .op_cnt(op_cnt)
  );

  // The shared combinational adder the arbiter fronts.
  assign {add_c, add_o} = add_a + add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [REQ_NUM-1:0] oh;
    int                 id;
    logic [BIT_NUM-1:0] o;
    logic               c;
    logic [CNT_BIT-1:0] cnt;
    int                 scyc;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int                 mptr = 0;
  logic [CNT_BIT-1:0] mcnt = '0;

  function automatic int pick(input logic [REQ_NUM-1:0] mask, input int p);
    for (int k = 0; k < REQ_NUM; k++)
      if (mask[(p + k) % REQ_NUM]) return (p + k) % REQ_NUM;
    return -1;
  endfunction

  // ---------------- monitor ----------------
  bit                 mon_en = 0;
  bit                 cur_active = 0;
  exp_t               cur;
  exp_t               e;
  logic [REQ_NUM-1:0] last_valid = '0;
  logic               rdy_edge;

  always begin
    @(posedge clk);
    rdy_edge = rsp_ready;
    #1;
    if (!mon_en) begin
      cur_active = 0;
      last_valid = '0;
    end else begin
      if (last_valid != 0 && rdy_edge) begin
        chk("hs_clear", 32'(rsp_valid), 0);
        chk("op_cnt", 32'(op_cnt), 32'(cur.cnt));
        cur_active = 0;
      end
      if (gnt != 0) begin
        if (gq.size() == 0) chk("unexp_gnt", 32'(gnt), 0);
        else begin
          e = gq.pop_front();
          chk("gnt", 32'(gnt), 32'(e.oh));
          chk("gnt_cyc", 32'(cyc), 32'(e.scyc));
          chk("busy_gnt", 32'(busy), 1);
        end
      end
      if (rsp_valid != 0) begin
        if (!cur_active) begin
          if (rq.size() == 0) chk("unexp_rsp", 32'(rsp_valid), 0);
          else begin
            cur = rq.pop_front();
            cur_active = 1;
            chk("rsp_cyc", 32'(cyc), 32'(cur.scyc + 1));
          end
        end else begin
          chk("stall_gnt", 32'(gnt), 0);
        end
        if (cur_active) begin
          chk("rsp_valid", 32'(rsp_valid), 32'(cur.oh));
          chk("rsp_o", 32'(rsp_o), 32'(cur.o));
          chk("rsp_c", 32'(rsp_c), 32'(cur.c));
          chk("rsp_id", 32'(rsp_id), 32'(cur.id));
          chk("busy_rsp", 32'(busy), 1);
        end
      end else if (cur_active) begin
        chk("rsp_dropped", 32'(rsp_valid), 32'(cur.oh));
        cur_active = 0;
      end
      last_valid = rsp_valid;
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic do_txn(input logic [REQ_NUM-1:0] mask,
                        input logic [REQ_NUM*BIT_NUM-1:0] av, bv,
                        input int stall, input int gap, input bit hold);
    exp_t x;
    int   w;
    logic [BIT_NUM:0] s;
    req = mask; a_in = av; b_in = bv; rsp_ready = 1'($urandom);
    @(posedge clk);
    w = pick(mask, mptr);
    s = {1'b0, av[w*BIT_NUM +: BIT_NUM]} + {1'b0, bv[w*BIT_NUM +: BIT_NUM]};
    mcnt   = mcnt + 1'b1;
    x.oh   = REQ_NUM'(1) << w;
    x.id   = w;
    x.o    = s[BIT_NUM-1:0];
    x.c    = s[BIT_NUM];
    x.cnt  = mcnt;
    x.scyc = cyc + 1;
    gq.push_back(x);
    rq.push_back(x);
    mptr = (w + 1) % REQ_NUM;
    @(negedge clk);
    // CALC: everything but the clock is ignored
    if (!hold) req = REQ_NUM'($urandom);
    a_in = ($urandom); b_in = ($urandom); rsp_ready = 1'($urandom);
    @(negedge clk);
    for (int k = 0; k < stall; k++) begin
      rsp_ready = 1'b0;
      if (!hold) req = REQ_NUM'($urandom);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < gap; k++) begin
      req = '0; rsp_ready = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic reset_test();
    logic [REQ_NUM-1:0] m;
    int w;
    mon_en = 0;
    m = REQ_NUM'($urandom_range(1, 15));
    req = m; a_in = $urandom; b_in = $urandom; rsp_ready = 1'b1;
    w = pick(m, mptr);
    @(posedge clk); #1;
    chk("rst_pre_gnt", 32'(gnt), 32'(REQ_NUM'(1) << w));
    #1 reset = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_o_c_id", 32'({rsp_o, rsp_c, rsp_id}), 0);
    chk("rst_add", 32'({add_a, add_b}), 0);
    chk("rst_cnt", 32'(op_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1; req = '0;
    mptr = 0; mcnt = '0;
    mon_en = 1;
    // any response here would be a leftover of the discarded operation
    repeat (4) @(negedge clk);
    do_txn(4'b0010, $urandom, $urandom, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_gnt", 32'(gnt), 0);
    chk("init_valid", 32'(rsp_valid), 0);
    chk("init_o_c_id", 32'({rsp_o, rsp_c, rsp_id}), 0);
    chk("init_cnt", 32'(op_cnt), 0);
    chk("init_busy", 32'(busy), 0);
    reset = 1'b1;
    @(negedge clk);
    // idle with no request: nothing moves
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    mon_en = 1;

    do_txn(4'b0001, 16'h0003, 16'h0005, 0, 1, 0);   // 3+5
    do_txn(4'b0100, 16'h0900, 16'h0900, 0, 1, 0);   // 9+9 carries
    do_txn(4'b1000, $urandom, $urandom, 0, 0, 0);   // brings ptr back to 0
    for (int i = 0; i < 6; i++) do_txn(4'b1111, $urandom, $urandom, 0, 0, 1);
    do_txn(REQ_NUM'($urandom_range(1, 15)), $urandom, $urandom, 5, 0, 0);
    reset_test();
    for (int i = 0; i < 300; i++)
      do_txn(REQ_NUM'($urandom_range(1, 15)), $urandom, $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
             ($urandom_range(0, 3) == 0) ? 1 : 0, 0);

    req = '0;
    repeat (4) @(negedge clk);
    chk("gq_left", gq.size(), 0);
    chk("rq_left", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
